// File: rtl/mux_pkg.sv
// Shared definitions for the stream multiplexers: channel limit, index type and
// the one-hot decode used to steer ready back to a single channel.
package mux_pkg;

  localparam int MUX_MAX_N = 16;
  localparam int MUX_IDX_W = $clog2(MUX_MAX_N);

  typedef logic [MUX_IDX_W-1:0] sel_t;

  function automatic logic [MUX_MAX_N-1:0] onehot_from_idx(input sel_t idx);
    logic [MUX_MAX_N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting channel at or above ptr, with wrap.
// Zero latency, no state; the pointer lives in the caller.
`ifdef MUX_STREAM_RR_EN
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  int idx;

  // Walk from the farthest offset down so the nearest requester wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt_idx = idx[SELW-1:0];
        gnt_any = 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/mux_stream.sv
// Registered N:1 valid/ready stream mux: 1-cycle latency, full throughput; stalls all inputs
// while a held beat is not taken. Round-robin selection exists only with MUX_STREAM_RR_EN.
module mux_stream
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
`ifdef MUX_STREAM_RR_EN
  input  logic               rr_mode,
`endif
  input  logic [SELW-1:0]    sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               sel_err
);

  localparam logic [SELW:0] N_IDX = (SELW + 1)'(N);

  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [SELW-1:0]      out_sel_q, out_sel_d;
  logic                 load, accept, g_ok, sel_oob;
  logic [SELW-1:0]      g;
  logic [MUX_MAX_N-1:0] oh_full;

  assign sel_oob = {1'b0, sel} >= N_IDX;

`ifdef MUX_STREAM_RR_EN
  logic [SELW-1:0] ptr_q, ptr_d, rr_idx;
  logic            rr_any;

  rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );
`endif

  always_comb begin
    g    = sel;
    g_ok = !sel_oob;
`ifdef MUX_STREAM_RR_EN
    if (rr_mode) begin
      g    = rr_idx;
      g_ok = rr_any;
    end
`endif
  end

  // Ready and the select error are held low while reset is asserted.
  always_comb begin
    load     = !out_valid_q || out_ready;
    oh_full  = onehot_from_idx(sel_t'(g));
    in_ready = '0;
    if (rst && load && g_ok) in_ready = oh_full[N-1:0];
    accept   = |(in_ready & in_valid);
    sel_err  = rst && load && sel_oob;
`ifdef MUX_STREAM_RR_EN
    if (rr_mode) sel_err = 1'b0;
`endif
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_sel_d   = g;
      out_data_d  = '0;
      for (int i = 0; i < N; i++) begin
        if (g == SELW'(i)) out_data_d = in_data[i*WIDTH +: WIDTH];
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef MUX_STREAM_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (rr_mode && accept) ptr_d = (g == SELW'(N - 1)) ? '0 : g + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_stream.sv
// Self-checking bench for mux_stream: a 4-channel instance driven against a scoreboard
// and a 3-channel instance for out-of-range select behaviour.
module tb_mux_stream;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [1:0]     sel4, os4, sel3, os3;
  logic [3:0]     iv4, ir4;
  logic [2:0]     iv3, ir3;
  logic [4*W-1:0] id4;
  logic [3*W-1:0] id3;
  logic           ov4, or4, se4, ov3, or3, se3;
  logic [W-1:0]   od4, od3;
`ifdef MUX_STREAM_RR_EN
  logic           rr4, rr3;
`endif

  mux_stream #(.WIDTH(W), .N(4)) u_dut4 (
    .clk(clk), .rst(rst),
`ifdef MUX_STREAM_RR_EN
    .rr_mode(rr4),
`endif
    .sel(sel4), .in_valid(iv4), .in_data(id4), .in_ready(ir4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_sel(os4), .sel_err(se4)
  );

  mux_stream #(.WIDTH(W), .N(3)) u_dut3 (
    .clk(clk), .rst(rst),
`ifdef MUX_STREAM_RR_EN
    .rr_mode(rr3),
`endif
    .sel(sel3), .in_valid(iv3), .in_data(id3), .in_ready(ir3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .out_sel(os3), .sel_err(se3)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic [1:0]   s;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];
  beat_t m_beat;
  logic  m_vld;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One fixed-select cycle on the 4-channel instance with the expected beat queued on accept.
  task automatic cyc4(input logic [1:0] s, input logic [3:0] v, input logic ordy,
                      input logic [4*W-1:0] d, input string tag);
    logic       ld, acc;
    logic [3:0] er;
    @(negedge clk);
    sel4 = s; iv4 = v; or4 = ordy; id4 = d;
    #1;
    ld  = !m_vld || ordy;
    er  = ld ? (4'b0001 << s) : 4'b0000;
    acc = (er & v) != 4'b0000;
    check({tag, ".rdy"}, 64'(ir4), 64'(er));
    check({tag, ".err"}, 64'(se4), 64'd0);
    if (acc) begin
      sb.push_back({d[s*W +: W], s});
      m_vld = 1'b1;
    end else if (ordy) begin
      m_vld = 1'b0;
    end
    @(posedge clk); #1;
    check({tag, ".vld"}, 64'(ov4), 64'(m_vld));
    if (acc && sb.size() > 0) m_beat = sb.pop_front();
    if (m_vld) begin
      check({tag, ".dat"}, 64'(od4), 64'(m_beat.d));
      check({tag, ".sel"}, 64'(os4), 64'(m_beat.s));
    end
  endtask

`ifdef MUX_STREAM_RR_EN
  task automatic rr_step(input logic [3:0] v, input logic [1:0] exp_s, input string tag);
    logic [4*W-1:0] d;
    beat_t          b;
    d = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    @(negedge clk);
    rr4 = 1'b1; iv4 = v; or4 = 1'b1; id4 = d; sel4 = 2'd3;
    #1;
    check({tag, ".rdy"}, 64'(ir4), 64'(4'b0001 << exp_s));
    sb.push_back({d[exp_s*W +: W], exp_s});
    @(posedge clk); #1;
    b = sb.pop_front();
    check({tag, ".vld"}, 64'(ov4), 64'd1);
    check({tag, ".sel"}, 64'(os4), 64'(b.s));
    check({tag, ".dat"}, 64'(od4), 64'(b.d));
  endtask
`endif

  initial begin
    rst = 1'b0; m_vld = 1'b0;
    sel4 = 2'd1; iv4 = 4'hF; or4 = 1'b1; id4 = '1;
    sel3 = 2'd3; iv3 = 3'b111; or3 = 1'b1; id3 = '1;
`ifdef MUX_STREAM_RR_EN
    rr4 = 1'b0; rr3 = 1'b0;
`endif
    #22;
    check("rst.vld", 64'(ov4), 64'd0);
    check("rst.dat", 64'(od4), 64'd0);
    check("rst.sel", 64'(os4), 64'd0);
    check("rst.rdy", 64'(ir4), 64'd0);
    check("rst.err3", 64'(se3), 64'd0);
    check("rst.rdy3", 64'(ir3), 64'd0);
    @(negedge clk);
    rst = 1'b1; iv4 = '0; sel3 = 2'd0; iv3 = '0;

    cyc4(2'd2, 4'b0100, 1'b1, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}, "fix2");
    check("fix2.const", 64'(od4), 64'hDEADBEEF);
    cyc4(2'd3, 4'b0000, 1'b1, '0, "idle3");

    // Backpressure: hold 0x11 for three cycles while channel 1 waits with 0x22.
    cyc4(2'd0, 4'b0001, 1'b0, {96'h0, 32'h11}, "bp.cap");
    for (int i = 0; i < 3; i++) cyc4(2'd1, 4'b0010, 1'b0, {64'h0, 32'h22, 32'h0}, "bp.hold");
    check("bp.held", 64'(od4), 64'h11);
    cyc4(2'd1, 4'b0010, 1'b1, {64'h0, 32'h22, 32'h0}, "bp.rel");
    check("bp.new", 64'(od4), 64'h22);

    for (int i = 0; i < 8; i++)
      cyc4(2'd1, 4'b0010, 1'b1, {64'h0, 32'(32'hA000 + i), 32'h0}, "strm");
    cyc4(2'd1, 4'b0000, 1'b1, '0, "drain");

    // Out-of-range select on the 3-channel instance.
    @(negedge clk);
    sel3 = 2'd0; iv3 = 3'b001; id3 = {32'h3, 32'h2, 32'hA0}; or3 = 1'b0;
    #1 check("oob.rdy0", 64'(ir3), 64'b001);
    @(posedge clk); #1;
    check("oob.vld0", 64'(ov3), 64'd1);
    check("oob.dat0", 64'(od3), 64'hA0);
    @(negedge clk);
    sel3 = 2'd3; iv3 = 3'b111;
    #1;
    check("oob.rdy.hold", 64'(ir3), 64'd0);
    check("oob.err.hold", 64'(se3), 64'd0);
    @(negedge clk);
    or3 = 1'b1;
    #1;
    check("oob.rdy.ld", 64'(ir3), 64'd0);
    check("oob.err.ld", 64'(se3), 64'd1);
    @(posedge clk); #1;
    check("oob.drain", 64'(ov3), 64'd0);
    check("oob.keep", 64'(od3), 64'hA0);
    @(negedge clk); #1;
    check("oob.err.idle", 64'(se3), 64'd1);
    check("oob.rdy.idle", 64'(ir3), 64'd0);
    @(posedge clk); #1;
    check("oob.vld.idle", 64'(ov3), 64'd0);
`ifdef MUX_STREAM_RR_EN
    @(negedge clk);
    rr3 = 1'b1;
    #1;
    check("oob.rr.err", 64'(se3), 64'd0);
    check("oob.rr.rdy", 64'(ir3), 64'b001);
    @(negedge clk);
    rr3 = 1'b0; iv3 = '0;

    rr_step(4'b1111, 2'd0, "rr.a0");
    rr_step(4'b1111, 2'd1, "rr.a1");
    rr_step(4'b1111, 2'd2, "rr.a2");
    rr_step(4'b1111, 2'd3, "rr.a3");
    rr_step(4'b1111, 2'd0, "rr.a4");
    rr_step(4'b1010, 2'd1, "rr.b0");
    rr_step(4'b1010, 2'd3, "rr.b1");
    rr_step(4'b1010, 2'd1, "rr.b2");
    rr_step(4'b1010, 2'd3, "rr.b3");
    @(negedge clk);
    rr4 = 1'b0;
`endif
    iv3 = '0;

    // Asynchronous reset while 0x55 is held.
    m_vld = ov4;
    cyc4(2'd0, 4'b0001, 1'b1, {96'h0, 32'h55}, "ar.cap");
    cyc4(2'd0, 4'b0000, 1'b0, '0, "ar.hold");
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("ar.vld", 64'(ov4), 64'd0);
    check("ar.dat", 64'(od4), 64'd0);
    check("ar.rdy", 64'(ir4), 64'd0);
    @(negedge clk);
    rst = 1'b1; m_vld = 1'b0; sb.delete();
    cyc4(2'd3, 4'b1000, 1'b1, {32'h77, 96'h0}, "ar.resume");
`ifdef MUX_STREAM_RR_EN
    rr_step(4'b1111, 2'd0, "ar.rr0");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
